timer_sequencer: RTL and testbench
==================================

// Module: timer_sequencer
// PURPOSE
//  Top-level mode controller for the kitchen timer: owns currentState[2:0] consumed by
//  every state_* block, loads the programmed MM:SS value, runs the 1 Hz BCD countdown
//  and drives the alarm. Sits between the button synchronizers and the 7-seg display mux.
// PARAMETERS
//  CLK_HZ         50_000_000  clk cycles per 1 s tick (prescaler terminal count + 1)
//  ALARM_SECONDS  10          seconds in ALARM before automatic return to IDLE (1..255)
// PORTS
//  clk           in   1   system clock, single clock domain
//  rst_n         in   1   reset, asynchronous assert, active-low
//  start         in   1   synchronized 1-cycle pulse, start/pause button
//  toggle        in   1   synchronized 1-cycle pulse, min/sec toggle button
//  increase      in   1   synchronized 1-cycle pulse, increment button
//  digitsIn      in   16  {min1,min0,sec1,sec0} BCD from the programming state block
//  currentState  out  3   mode: 0 IDLE, 1 PROGRAMMING, 2 COUNTDOWN, 3 PAUSED, 4 ALARM
//  digitsOut     out  16  BCD value for display
//  alarm         out  1   high throughout ALARM
//  buzzer        out  1   2 Hz square wave during ALARM, else 0
// BEHAVIOUR
//  Reset: currentState=0, count=16'h0000, prescaler=0, alarm=0, buzzer=0, alarm timer=0.
//  All state/count updates registered on posedge clk; outputs change 1 cycle after the pulse.
//  Simultaneous pulses: start > toggle > increase; lower-priority pulses in that cycle dropped.
//  IDLE: any pulse -> PROGRAMMING. digitsOut=16'h0000.
//  PROGRAMMING: digitsOut=digitsIn (combinational pass-through). toggle/increase ignored here.
//   start with digitsIn!=0 -> count<=digitsIn, prescaler<=0, -> COUNTDOWN.
//   start with digitsIn==0 -> stay PROGRAMMING.
//  COUNTDOWN: prescaler 0..CLK_HZ-1; tick when prescaler==CLK_HZ-1 (prescaler wraps to 0).
//   On tick: BCD decrement: sec0 9->borrow, sec1 5->borrow, min0 9->borrow, min1 dec.
//   Decrement landing on 0000 -> ALARM on the same edge (count shows 0000).
//   toggle -> IDLE (abort), count cleared. increase ignored. digitsOut=count.
//   Tick and toggle in same cycle: toggle wins, no decrement.
//  PAUSED: prescaler and count frozen; digitsOut=count; toggle -> IDLE.
//  ALARM: alarm=1; buzzer inverts every CLK_HZ/4 cycles starting at 0; alarm timer counts
//   1 s ticks; any pulse or ALARM_SECONDS-th tick -> IDLE, alarm=0, buzzer=0, count=0.
//  Illegal currentState 5..7 (SEU) -> IDLE next cycle, count cleared.
//  rst_n low mid-countdown: immediate return to reset values regardless of clk.
//  Input digits >9 / >5 are not sanitised; decrement from such digit treats it as value-1.
// CONFIGURATION
//  PAUSE_EN defined: start in COUNTDOWN -> PAUSED; start in PAUSED -> COUNTDOWN, prescaler
//   resumes from frozen value.
//  PAUSE_EN undefined: start in COUNTDOWN ignored; state 3 unreachable and treated as illegal
//   (-> IDLE); PAUSED logic not synthesised.
// STRUCTURE
//  Shared include timer_defs.vh: state encodings ST_IDLE..ST_ALARM (3-bit localparams),
//   BCD digit limits (9, 5), digit field slices of the 16-bit MM:SS word.
//  Sub-module bcd_mmss_down_counter: load/enable/value/zero outputs, pure BCD borrow chain.
//  timer_sequencer holds FSM, 1 Hz prescaler, alarm timer, buzzer divider, output mux.
// TESTING (bench uses CLK_HZ=8, ALARM_SECONDS=3)
//  Reset mid-run: rst_n low at arbitrary time -> currentState=0, digitsOut=0000, alarm=0 async.
//  IDLE, increase pulse -> currentState=1 next cycle; digitsIn=0000 then start -> stays 1.
//  digitsIn=16'h0100, start -> state 2; after 8 cycles digitsOut=0059; after 60 ticks
//   digitsOut=0000, state 4, alarm=1 on the same edge.
//  ALARM with no input -> buzzer period 4 cycles; after 3 ticks (24 cycles) state 0, alarm=0.
//  COUNTDOWN 0010, toggle+tick same cycle -> state 0, digitsOut=0000, no decrement.
//  PAUSE_EN: start at 0007 -> state 3, value holds 40 cycles; start -> state 2, next tick
//   0006. Without PAUSE_EN the same start is ignored; forcing state 3 -> state 0.

Source files
------------

// File: rtl/timer_sequencer_pkg.sv
// Shared types for the kitchen-timer sequencer: mode encoding, MM:SS BCD word layout
// and the single-digit borrow step used by the countdown.
package timer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PROGRAMMING = 3'd1,
    ST_COUNTDOWN   = 3'd2,
    ST_PAUSED      = 3'd3,
    ST_ALARM       = 3'd4
  } state_e;

  localparam logic [3:0] DIGIT_MAX_UNITS = 4'd9;
  localparam logic [3:0] DIGIT_MAX_TENS  = 4'd5;

  typedef struct packed {
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
  } mmss_t;

  typedef struct packed {
    logic       borrow;
    logic [3:0] digit;
  } digit_dec_t;

  // Out-of-range digits are not sanitised: anything non-zero simply loses one.
  function automatic digit_dec_t dec_digit(input logic [3:0] d, input logic [3:0] wrap_to);
    digit_dec_t r;
    if (d == 4'd0) begin
      r.borrow = 1'b1;
      r.digit  = wrap_to;
    end else begin
      r.borrow = 1'b0;
      r.digit  = d - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_sequencer_if.sv
// Button/digit bundle between the input synchronizers, the sequencer and the display mux.
interface timer_sequencer_if;
  logic        start;
  logic        toggle;
  logic        increase;
  logic [15:0] digitsIn;
  logic [2:0]  currentState;
  logic [15:0] digitsOut;
  logic        alarm;
  logic        buzzer;

  modport master (
    output start, toggle, increase, digitsIn,
    input  currentState, digitsOut, alarm, buzzer
  );

  modport slave (
    input  start, toggle, increase, digitsIn,
    output currentState, digitsOut, alarm, buzzer
  );
endinterface

// File: rtl/timer_sequencer_bcd_counter.sv
// MM:SS BCD down-counter: clear > load > enable; dec_zero flags that the next decrement lands on 00:00.
module timer_sequencer_bcd_counter
  import timer_sequencer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  load,
  input  logic  enable,
  input  mmss_t load_value,
  output mmss_t value,
  output logic  dec_zero
);

  mmss_t      dec_value;
  digit_dec_t s0, s1, m0;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    dec_value      = value;
    s0             = dec_digit(value.sec0, DIGIT_MAX_UNITS);
    s1             = dec_digit(value.sec1, DIGIT_MAX_TENS);
    m0             = dec_digit(value.min0, DIGIT_MAX_UNITS);
    dec_value.sec0 = s0.digit;
    if (s0.borrow) begin
      dec_value.sec1 = s1.digit;
      if (s1.borrow) begin
        dec_value.min0 = m0.digit;
        if (m0.borrow) dec_value.min1 = value.min1 - 4'd1;
      end
    end
  end

  assign dec_zero = (dec_value == '0);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      value <= '0;
    else if (clear)  value <= '0;
    else if (load)   value <= load_value;
    else if (enable) value <= dec_value;
  end

endmodule

// File: rtl/timer_sequencer.sv
// Kitchen-timer mode controller: FSM, 1 Hz prescaler, alarm timer, buzzer divider, display mux.
// Define PAUSE_EN to enable start/pause toggling between COUNTDOWN and PAUSED.
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int ALARM_SECONDS = 10
) (
  input logic               clk,
  input logic               rst_n,
  timer_sequencer_if.slave  bus
);

  localparam int PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BUZZ_DIV  = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int BUZZ_W    = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [PRESC_W-1:0] TICK_MAX   = PRESC_W'(CLK_HZ - 1);
  localparam logic [BUZZ_W-1:0]  BUZZ_LAST  = BUZZ_W'(BUZZ_DIV - 1);
  localparam logic [7:0]         ALARM_LAST = 8'(ALARM_SECONDS - 1);

  state_e             st;
  logic [PRESC_W-1:0] presc;
  logic [7:0]         alarm_sec;
  logic [BUZZ_W-1:0]  buzz_cnt;
  logic               alarm_q, buzzer_q;

  logic  toggle_p, any_p, tick, pause_req, alarm_done;
  logic  go_idle, cnt_load, cnt_enable, dec_zero;
  mmss_t count;
  logic [15:0] digits_out;

  always_comb begin
    toggle_p   = bus.toggle & ~bus.start;
    any_p      = bus.start | bus.toggle | bus.increase;
    tick       = (presc == TICK_MAX);
`ifdef PAUSE_EN
    pause_req  = bus.start;
`else
    pause_req  = 1'b0;
`endif
    cnt_load   = (st == ST_PROGRAMMING) && bus.start && (bus.digitsIn != 16'h0000);
    // An abort or pause on the tick edge wins: the count does not move.
    cnt_enable = (st == ST_COUNTDOWN) && tick && !toggle_p && !pause_req;
    alarm_done = tick && (alarm_sec == ALARM_LAST);
    go_idle    = 1'b0;
    case (st)
      ST_IDLE, ST_PROGRAMMING: go_idle = 1'b0;
      ST_COUNTDOWN:            go_idle = toggle_p;
`ifdef PAUSE_EN
      ST_PAUSED:               go_idle = toggle_p;
`endif
      ST_ALARM:                go_idle = any_p || alarm_done;
      default:                 go_idle = 1'b1;
    endcase
  end

  timer_sequencer_bcd_counter u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (go_idle),
    .load       (cnt_load),
    .enable     (cnt_enable),
    .load_value (mmss_t'(bus.digitsIn)),
    .value      (count),
    .dec_zero   (dec_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      presc     <= '0;
      alarm_sec <= '0;
      buzz_cnt  <= '0;
      alarm_q   <= 1'b0;
      buzzer_q  <= 1'b0;
    end else if (go_idle) begin
      st        <= ST_IDLE;
      presc     <= '0;
      alarm_sec <= '0;
      buzz_cnt  <= '0;
      alarm_q   <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (any_p) st <= ST_PROGRAMMING;
        ST_PROGRAMMING: begin
          if (cnt_load) begin
            st    <= ST_COUNTDOWN;
            presc <= '0;
          end
        end
        ST_COUNTDOWN: begin
`ifdef PAUSE_EN
          if (bus.start) st <= ST_PAUSED;
          else
`endif
          begin
            presc <= tick ? '0 : presc + 1'b1;
            if (cnt_enable && dec_zero) begin
              st        <= ST_ALARM;
              alarm_q   <= 1'b1;
              alarm_sec <= '0;
              buzz_cnt  <= '0;
              buzzer_q  <= 1'b0;
            end
          end
        end
`ifdef PAUSE_EN
        // Prescaler stays frozen so the interrupted second resumes where it left off.
        ST_PAUSED: if (bus.start) st <= ST_COUNTDOWN;
`endif
        ST_ALARM: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) alarm_sec <= alarm_sec + 8'd1;
          if (buzz_cnt == BUZZ_LAST) begin
            buzz_cnt <= '0;
            buzzer_q <= ~buzzer_q;
          end else begin
            buzz_cnt <= buzz_cnt + 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    digits_out = 16'h0000;
    case (st)
      ST_PROGRAMMING:         digits_out = bus.digitsIn;
      ST_COUNTDOWN, ST_ALARM: digits_out = count;
`ifdef PAUSE_EN
      ST_PAUSED:              digits_out = count;
`endif
      default:                digits_out = 16'h0000;
    endcase
  end

  assign bus.currentState = st;
  assign bus.digitsOut    = digits_out;
  assign bus.alarm        = alarm_q;
  assign bus.buzzer       = buzzer_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with CLK_HZ=8, ALARM_SECONDS=3; honours PAUSE_EN when defined.
module tb_timer_sequencer;

  localparam int CLK_HZ        = 8;
  localparam int ALARM_SECONDS = 3;

  typedef struct {
    logic        s, t, i;
    logic [15:0] din;
    logic [2:0]  st;
    logic [15:0] dig;
    logic        al;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  timer_sequencer_if bus();

  timer_sequencer #(.CLK_HZ(CLK_HZ), .ALARM_SECONDS(ALARM_SECONDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] st, input logic [15:0] dig,
                            input logic al, input logic bz);
    check({name, ".state"},  16'(bus.currentState), 16'(st));
    check({name, ".digits"}, bus.digitsOut, dig);
    check({name, ".alarm"},  16'(bus.alarm), 16'(al));
    check({name, ".buzzer"}, 16'(bus.buzzer), 16'(bz));
  endtask

  task automatic cycle(input logic s, input logic t, input logic i);
    bus.start    = s;
    bus.toggle   = t;
    bus.increase = i;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.toggle   = 1'b0;
    bus.increase = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic s, input logic t, input logic i, input logic [15:0] din,
                              input logic [2:0] st, input logic [15:0] dig, input logic al);
    vec_t v;
    v.s = s; v.t = t; v.i = i; v.din = din; v.st = st; v.dig = dig; v.al = al;
    return v;
  endfunction

  // Whole seconds to {min1,min0,sec1,sec0} BCD.
  function automatic logic [15:0] mmss(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.toggle = 1'b0; bus.increase = 1'b0; bus.digitsIn = 16'h0000;
    #1;
    check_outs("reset", 3'd0, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Programming path and start of the countdown from 01:00.
    vecs.push_back(mk(0, 0, 0, 16'h0000, 3'd0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 3'd1, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 3'd1, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h1234, 3'd1, 16'h1234, 0));
    vecs.push_back(mk(0, 1, 0, 16'h1234, 3'd1, 16'h1234, 0));
    vecs.push_back(mk(0, 0, 1, 16'h1234, 3'd1, 16'h1234, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 3'd1, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0100, 3'd2, 16'h0100, 0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(0, 0, (k == 2), 16'h0999, 3'd2, 16'h0100, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0999, 3'd2, 16'h0059, 0));

    foreach (vecs[i]) begin
      bus.digitsIn = vecs[i].din;
      cycle(vecs[i].s, vecs[i].t, vecs[i].i);
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].dig, vecs[i].al, 1'b0);
    end

    // Remaining 59 seconds; ALARM must coincide with the 00:00 edge.
    for (int k = 2; k <= 60; k++) begin
      for (int c = 1; c <= 8; c++) begin
        idle(1);
        if (c == 7) begin
          check($sformatf("cd%0d.pre_digits", k), bus.digitsOut, mmss(61 - k));
          check($sformatf("cd%0d.pre_state", k), 16'(bus.currentState), 16'd2);
        end
        if (c == 8) begin
          check($sformatf("cd%0d.digits", k), bus.digitsOut, mmss(60 - k));
          check($sformatf("cd%0d.state", k), 16'(bus.currentState), (k == 60) ? 16'd4 : 16'd2);
          check($sformatf("cd%0d.alarm", k), 16'(bus.alarm), (k == 60) ? 16'd1 : 16'd0);
        end
      end
    end

    // Alarm: 4-cycle buzzer period, automatic exit after 3 seconds.
    for (int k = 1; k <= 24; k++) begin
      idle(1);
      if (k < 24) check_outs($sformatf("alarm%0d", k), 3'd4, 16'h0000, 1'b1, 1'((k / 2) % 2));
      else        check_outs("alarm_exit", 3'd0, 16'h0000, 1'b0, 1'b0);
    end

    // Abort on the tick edge: toggle wins, no decrement.
    cycle(0, 0, 1);
    bus.digitsIn = 16'h0010;
    cycle(1, 0, 0);
    check_outs("abort.load", 3'd2, 16'h0010, 1'b0, 1'b0);
    idle(7);
    check_outs("abort.pre", 3'd2, 16'h0010, 1'b0, 1'b0);
    cycle(0, 1, 0);
    check_outs("abort", 3'd0, 16'h0000, 1'b0, 1'b0);

    // Alarm ended early by a button pulse.
    cycle(0, 0, 1);
    bus.digitsIn = 16'h0001;
    cycle(1, 0, 0);
    idle(7);
    check_outs("short.pre", 3'd2, 16'h0001, 1'b0, 1'b0);
    idle(1);
    check_outs("short.alarm", 3'd4, 16'h0000, 1'b1, 1'b0);
    idle(3);
    cycle(0, 0, 1);
    check_outs("short.exit", 3'd0, 16'h0000, 1'b0, 1'b0);

    // Start during countdown: pause/resume, or ignored without the pause feature.
    cycle(0, 0, 1);
    bus.digitsIn = 16'h0007;
    cycle(1, 0, 0);
    idle(3);
    cycle(1, 0, 0);
`ifdef PAUSE_EN
    check_outs("pause", 3'd3, 16'h0007, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      idle(1);
      check_outs($sformatf("paused%0d", k), 3'd3, 16'h0007, 1'b0, 1'b0);
    end
    cycle(1, 0, 0);
    check_outs("resume", 3'd2, 16'h0007, 1'b0, 1'b0);
    idle(4);
`else
    check_outs("start_ignored", 3'd2, 16'h0007, 1'b0, 1'b0);
    idle(3);
`endif
    check_outs("tick.pre", 3'd2, 16'h0007, 1'b0, 1'b0);
    idle(1);
    check_outs("tick", 3'd2, 16'h0006, 1'b0, 1'b0);
    cycle(0, 1, 0);
    check_outs("tick.abort", 3'd0, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of ALARM, between clock edges.
    cycle(0, 0, 1);
    bus.digitsIn = 16'h0001;
    cycle(1, 0, 0);
    idle(8);
    check_outs("rst.alarm", 3'd4, 16'h0000, 1'b1, 1'b0);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rst.async", 3'd0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    check_outs("rst.after", 3'd0, 16'h0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
